// File: rtl/sweep_log_pkg.sv
// sweep_log_pkg: shared states and record geometry for the sweep result logger
package sweep_log_pkg;
  typedef enum logic [3:0] {IDLE, CAPTURE, HDR, LEN_H, LEN_L, RD, DATA, CKSUM, DONE} logger_state_t;
  localparam int RECORD_BYTES = 12;
  localparam int RECORD_WIDTH = 3 * 32;
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
endpackage

// File: rtl/result_ram.sv
// result_ram: simple dual-port record buffer with one write port and a registered read port
module result_ram #(
  parameter int W  = 96,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sweep_result_logger.sv
// sweep_result_logger: buffers sweep records and dumps them as a framed, checksummed byte stream
module sweep_result_logger
  import sweep_log_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         N_POINTS   = 200,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic                         clk125,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         fin2,
  input  logic        [DATA_WIDTH-1:0] incrementado,
  input  logic signed [DATA_WIDTH-1:0] MODULO,
  input  logic signed [DATA_WIDTH-1:0] PHASE,
  input  logic                         fin,
  output logic        [7:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         overflow,
  output logic        [ADDR_WIDTH-1:0] n_captured,
  output logic                         dump_done
);
  localparam int REC_W = RECORD_WIDTH * DATA_WIDTH / 32;
  localparam int REC_B = RECORD_BYTES * DATA_WIDTH / 32;
  localparam int IDX_W = $clog2(REC_B);
  localparam logic [ADDR_WIDTH-1:0] N_MAX = ADDR_WIDTH'(N_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_B - 1);
  logger_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] cksum_q, cksum_d;
  logic ovf_q, ovf_d;
  logic we, re, xfer;
  logic [15:0] len;
  logic [REC_W-1:0] rdata;
  result_ram #(.W(REC_W), .AW(ADDR_WIDTH)) u_ram (
    .clk  (clk125),
    .we   (we),
    .waddr(cnt_q),
    .wdata({incrementado, MODULO, PHASE}),
    .re   (re),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  always_comb begin
    len = 16'(cnt_q);
    tx_valid = state_q inside {HDR, LEN_H, LEN_L, DATA, CKSUM};
    tx_data = state_q == HDR   ? SYNC_WORD :
              state_q == LEN_H ? len[15:8] :
              state_q == LEN_L ? len[7:0] :
              state_q == DATA  ? 8'(rdata >> (REC_W - 8 - 8 * int'(idx_q))) :
              state_q == CKSUM ? cksum_q : 8'h00;
    xfer = tx_valid && tx_ready;
    busy = state_q != IDLE;
    dump_done = state_q == DONE;
    overflow = ovf_q;
    n_captured = cnt_q;
    we = state_q == CAPTURE && !start && fin2 && cnt_q < N_MAX;
    re = state_q == RD;
    state_d = state_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    rd_ptr_d = rd_ptr_q;
    idx_d = idx_q;
    cksum_d = xfer && state_q inside {LEN_H, LEN_L, DATA} ? cksum_q ^ tx_data : cksum_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CAPTURE;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      CAPTURE: if (start) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        cnt_d = we ? cnt_q + 1'b1 : cnt_q;
        ovf_d = ovf_q | (fin2 & ~we);
        if (fin) begin
          state_d = HDR;
          cksum_d = 8'h00;
          rd_ptr_d = '0;
          idx_d = '0;
        end
      end
      HDR:   state_d = xfer ? LEN_H : HDR;
      LEN_H: state_d = xfer ? LEN_L : LEN_H;
      LEN_L: state_d = !xfer ? LEN_L : cnt_q == '0 ? CKSUM : RD;
      RD:    state_d = DATA;
      DATA: if (xfer) begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d = rd_ptr_q + 1'b1 == cnt_q ? CKSUM : RD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CKSUM: state_d = xfer ? DONE : CKSUM;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk125) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      rd_ptr_q <= '0;
      idx_q <= '0;
      cksum_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q <= idx_d;
      cksum_q <= cksum_d;
    end
  end
endmodule

// File: tb/tb_sweep_result_logger.sv
// tb_sweep_result_logger: directed self-checking bench for the sweep result logger
module tb_sweep_result_logger;
  logic clk125 = 1'b0;
  logic reset, start, fin2, fin, tx_ready;
  logic [31:0] incrementado;
  logic signed [31:0] MODULO, PHASE;
  logic [7:0] tx_data;
  logic tx_valid, busy, overflow, dump_done;
  logic [7:0] n_captured;
  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [95:0] recs[$];
  sweep_result_logger dut (
    .clk125      (clk125),
    .reset       (reset),
    .start       (start),
    .fin2        (fin2),
    .incrementado(incrementado),
    .MODULO      (MODULO),
    .PHASE       (PHASE),
    .fin         (fin),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overflow    (overflow),
    .n_captured  (n_captured),
    .dump_done   (dump_done)
  );
  always #5 clk125 = ~clk125;
  task automatic tick;
    @(posedge clk125);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
    end
  endtask
  task automatic rec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    incrementado = a;
    MODULO = b;
    PHASE = c;
    fin2 = 1'b1;
    tick();
    fin2 = 1'b0;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic pulse_fin;
    fin = 1'b1;
    tick();
    fin = 1'b0;
  endtask
  task automatic build_exp;
    logic [7:0] cs, b;
    logic [15:0] l;
    l = 16'(recs.size());
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    cs = l[15:8] ^ l[7:0];
    foreach (recs[r]) begin
      for (int k = 0; k < 12; k++) begin
        b = recs[r][95 - 8 * k -: 8];
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
  endtask
  task automatic collect(input bit bp, input int stop_after);
    logic [7:0] held;
    bit hold, stop;
    int cyc;
    hold = 1'b0;
    stop = 1'b0;
    held = 8'h00;
    cyc = 0;
    got = {};
    while (cyc < 10000 && !stop && !dump_done) begin
      if (hold) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(held));
      end
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        stop = got.size() == stop_after;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    if (!stop) begin
      chk("dump_done_pulse", 32'(dump_done), 32'd1);
      tick();
      chk("dump_done_single", 32'(dump_done), 32'd0);
      chk("busy_after_dump", 32'(busy), 32'd0);
    end
  endtask
  task automatic cmp(input string tag);
    int bad;
    bad = -1;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
    chk({tag, "_first_bad_byte"}, 32'(bad), 32'hFFFF_FFFF);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    fin2 = 1'b0;
    fin = 1'b0;
    tx_ready = 1'b1;
    incrementado = '0;
    MODULO = '0;
    PHASE = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_n_captured", 32'(n_captured), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    fin = 1'b1;
    rec(32'h1, 32'h2, 32'h3);
    fin = 1'b0;
    tick();
    chk("idle_ignore_busy", 32'(busy), 32'd0);
    chk("idle_ignore_count", 32'(n_captured), 32'd0);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00,
              8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'h9C, 8'h63};
    pulse_start();
    chk("capture_busy", 32'(busy), 32'd1);
    rec(32'h01020304, 32'd5, -32'sd100);
    chk("single_count", 32'(n_captured), 32'd1);
    pulse_fin();
    collect(1'b0, 0);
    cmp("single");
    pulse_start();
    rec(32'h01020304, 32'd5, -32'sd100);
    pulse_fin();
    collect(1'b1, 0);
    cmp("backpressure");
    pulse_start();
    recs = {};
    for (int i = 0; i <= 200; i++) begin
      rec(32'(i), 32'd0, 32'd0);
      if (i < 200) recs.push_back({32'(i), 64'd0});
    end
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_count", 32'(n_captured), 32'd200);
    pulse_fin();
    collect(1'b0, 0);
    build_exp();
    cmp("full");
    chk("full_len_h", 32'(got[1]), 32'h00);
    chk("full_len_l", 32'(got[2]), 32'hC8);
    pulse_start();
    chk("restart_overflow_clr", 32'(overflow), 32'd0);
    chk("restart_count_clr", 32'(n_captured), 32'd0);
    pulse_fin();
    collect(1'b0, 0);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    cmp("empty");
    pulse_start();
    fin = 1'b1;
    rec(32'hDEADBEEF, 32'h7FFFFFFF, 32'h80000000);
    fin = 1'b0;
    recs = {};
    recs.push_back({32'hDEADBEEF, 32'h7FFFFFFF, 32'h80000000});
    collect(1'b0, 0);
    build_exp();
    cmp("simul");
    chk("simul_len_l", 32'(got[2]), 32'h01);
    pulse_start();
    rec(32'hCAFEBABE, 32'h12345678, 32'hFFFFFFFF);
    pulse_fin();
    collect(1'b0, 5);
    chk("middump_bytes", 32'(got.size()), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("middump_tx_valid", 32'(tx_valid), 32'd0);
    chk("middump_busy", 32'(busy), 32'd0);
    chk("middump_count", 32'(n_captured), 32'd0);
    pulse_start();
    rec(32'h00000010, -32'sd2, 32'h00000300);
    pulse_fin();
    recs = {};
    recs.push_back({32'h00000010, 32'hFFFFFFFE, 32'h00000300});
    collect(1'b1, 0);
    build_exp();
    cmp("after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
